// File: rtl/dds_mod_core.sv
// dds_mod_core: two-channel DDS modulation engine.
// Carrier and modulator phase accumulators drive external sine ROMs. The carrier
// sample is amplitude scaled and then combined with the modulator as CW/AM/FM/DSB.
// The result saturates and leaves as an offset-binary DAC sample.
// Configuration is written into shadow registers and copied to the active set by a commit strobe.
// Optional feature macro: DDS_DITHER_EN adds LFSR phase dither ahead of ROM address truncation.
module dds_mod_core #(
   parameter int PHASE_W = 32,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [2:0]         cfg_addr,
   input  logic [PHASE_W-1:0] cfg_data,
   output logic [ADDR_W-1:0]  rom_addr_car,
   input  logic [DATA_W-1:0]  rom_data_car,
   output logic [ADDR_W-1:0]  rom_addr_mod,
   input  logic [DATA_W-1:0]  rom_data_mod,
   output logic [DATA_W-1:0]  dac_out,
   output logic               out_valid,
   output logic               car_wrap
);

   typedef enum logic [1:0] {MODE_CW = 2'd0, MODE_AM = 2'd1, MODE_FM = 2'd2, MODE_DSB = 2'd3} mode_t;

   localparam logic [15:0]        AMP_UNITY = 16'h8000;
   localparam logic [DATA_W-1:0]  DAC_MID   = {1'b1, {(DATA_W-1){1'b0}}};
   // Wide enough for product of two DATA_W+1 bit signed values plus headroom.
   localparam int                 PW        = 2*DATA_W + 8;
   localparam logic signed [PW-1:0] HALF    = PW'(2**(DATA_W-1));

   // ---------------- configuration ----------------
   logic               commit_pend, phrst_pend, cfg_fire;
   logic [PHASE_W-1:0] sh_car_ftw, sh_mod_ftw, car_ftw, mod_ftw;
   logic [15:0]        sh_car_amp, car_amp;
   logic [DATA_W-1:0]  sh_am_depth, am_depth;
   mode_t              sh_mode, mode;
   logic [4:0]         sh_fm_shift, fm_shift;

   // The config port stalls only while a commit is being copied.
   assign cfg_ready = ~commit_pend;
   assign cfg_fire  = cfg_valid & cfg_ready;

   // Shadow register writes; amplitude is clamped to unity at write time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_car_ftw  <= '0;
         sh_mod_ftw  <= '0;
         sh_car_amp  <= AMP_UNITY;
         sh_am_depth <= '0;
         sh_mode     <= MODE_CW;
         sh_fm_shift <= '0;
      end else if (cfg_fire) begin
         case (cfg_addr)
            3'd0: sh_car_ftw  <= cfg_data;
            3'd1: sh_mod_ftw  <= cfg_data;
            3'd2: sh_car_amp  <= (cfg_data > PHASE_W'(AMP_UNITY)) ? AMP_UNITY : cfg_data[15:0];
            3'd3: sh_am_depth <= cfg_data[DATA_W-1:0];
            3'd4: sh_mode     <= mode_t'(cfg_data[1:0]);
            3'd5: sh_fm_shift <= cfg_data[4:0];
            default: ;
         endcase
      end
   end

   // Strobes are registered so that they act in the cycle after acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_pend <= 1'b0;
         phrst_pend  <= 1'b0;
      end else begin
         commit_pend <= cfg_fire && (cfg_addr == 3'd7);
         phrst_pend  <= cfg_fire && (cfg_addr == 3'd6);
      end
   end

   // Active register set, loaded from the shadows as one atomic update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_ftw  <= '0;
         mod_ftw  <= '0;
         car_amp  <= AMP_UNITY;
         am_depth <= '0;
         mode     <= MODE_CW;
         fm_shift <= '0;
      end else if (commit_pend) begin
         car_ftw  <= sh_car_ftw;
         mod_ftw  <= sh_mod_ftw;
         car_amp  <= sh_car_amp;
         am_depth <= sh_am_depth;
         mode     <= sh_mode;
         fm_shift <= sh_fm_shift;
      end
   end

   // ---------------- S0: phase accumulators ----------------
   logic signed [DATA_W-1:0] m_s, car_a;
   logic [PHASE_W-1:0]       car_ph, mod_ph, fm_dev, car_inc;
   logic [PHASE_W:0]         car_sum;
   logic                     wrap0, wrap1, wrap2, wrap3;

   // FM deviation comes from the modulator sample currently held in S3.
   always_comb begin
      fm_dev  = PHASE_W'(m_s) << fm_shift;
      car_inc = (mode == MODE_FM) ? car_ftw + fm_dev : car_ftw;
      car_sum = {1'b0, car_ph} + {1'b0, car_inc};
   end

   // Accumulate; a phase reset strobe overrides the increment and clears the wrap flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_ph <= '0;
         mod_ph <= '0;
         wrap0  <= 1'b0;
      end else if (phrst_pend) begin
         car_ph <= '0;
         mod_ph <= '0;
         wrap0  <= 1'b0;
      end else begin
         car_ph <= car_sum[PHASE_W-1:0];
         mod_ph <= mod_ph + mod_ftw;
         wrap0  <= car_sum[PHASE_W];
      end
   end

   // ---------------- S1: ROM address ----------------
   logic [PHASE_W-1:0] car_ph_d, mod_ph_d;
`ifdef DDS_DITHER_EN
   localparam int DITH_W = (PHASE_W - ADDR_W > 16) ? 16 : (PHASE_W - ADDR_W);
   logic [15:0] lfsr;

   // Fibonacci LFSR, taps 16,14,13,11, free running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 16'hACE1;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign car_ph_d = car_ph + PHASE_W'(lfsr[15 -: DITH_W]);
   assign mod_ph_d = mod_ph + PHASE_W'(lfsr[15 -: DITH_W]);
`else
   assign car_ph_d = car_ph;
   assign mod_ph_d = mod_ph;
`endif

   // Truncate phase to the top ADDR_W bits for the ROM lookup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_car <= '0;
         rom_addr_mod <= '0;
         wrap1        <= 1'b0;
         wrap2        <= 1'b0;
      end else begin
         rom_addr_car <= ADDR_W'(car_ph_d >> (PHASE_W - ADDR_W));
         rom_addr_mod <= ADDR_W'(mod_ph_d >> (PHASE_W - ADDR_W));
         wrap1        <= wrap0;
         wrap2        <= wrap1;   // tracks the S2 ROM access
      end
   end

   // ---------------- S3: signed conversion and amplitude ----------------
   logic signed [DATA_W-1:0]  car_s, mod_s;
   logic signed [DATA_W+16:0] car_prod;

   assign car_s    = {~rom_data_car[DATA_W-1], rom_data_car[DATA_W-2:0]};
   assign mod_s    = {~rom_data_mod[DATA_W-1], rom_data_mod[DATA_W-2:0]};
   assign car_prod = car_s * $signed({1'b0, car_amp});

   // Register scaled carrier and signed modulator (amp <= unity keeps car_a in range).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_a <= '0;
         m_s   <= '0;
         wrap3 <= 1'b0;
      end else begin
         car_a <= DATA_W'(car_prod >>> 15);
         m_s   <= mod_s;
         wrap3 <= wrap2;
      end
   end

   // ---------------- S4: modulation and saturation ----------------
   logic signed [PW-1:0]     ca_x, ms_x, dep_x, env, y;
   logic signed [DATA_W-1:0] y_sat;

   // Mode arithmetic uses the active mode directly, so a commit switches it without a flush.
   always_comb begin
      ca_x  = PW'(car_a);
      ms_x  = PW'(m_s);
      dep_x = PW'({1'b0, am_depth});
      env   = HALF + ((ms_x * dep_x) >>> DATA_W);
      case (mode)
         MODE_AM:  y = (ca_x * env)  >>> (DATA_W - 1);
         MODE_DSB: y = (ca_x * ms_x) >>> (DATA_W - 1);
         default:  y = ca_x;
      endcase
      if (y > HALF - 1)      y_sat = {1'b0, {(DATA_W-1){1'b1}}};
      else if (y < -HALF)    y_sat = {1'b1, {(DATA_W-1){1'b0}}};
      else                   y_sat = DATA_W'(y);
   end

   // ---------------- S5: output register ----------------
   logic [4:0] prime;

   // Offset-binary output plus the wrap flag delayed alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_out  <= DAC_MID;
         car_wrap <= 1'b0;
         prime    <= '0;
      end else begin
         dac_out  <= {~y_sat[DATA_W-1], y_sat[DATA_W-2:0]};
         car_wrap <= wrap3;
         prime    <= {prime[3:0], 1'b1};
      end
   end

   assign out_valid = prime[4];

endmodule

// File: tb/tb_dds_mod_core.sv
// tb_dds_mod_core: randomized self-checking bench for dds_mod_core.
// A cycle-level reference computes phases, ROM addresses and DAC samples with plain integer arithmetic.
module tb_dds_mod_core;
   localparam int PHASE_W = 32, ADDR_W = 12, DATA_W = 12;
   localparam longint MASK32 = 64'hFFFF_FFFF;

   logic        clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic        cfg_ready, out_valid, car_wrap;
   logic [11:0] rom_addr_car, rom_addr_mod, dac_out;
   logic [11:0] rom_data_car = '0, rom_data_mod = '0;

   int total = 0, bad = 0, cyc = 0;
   int sin_tab[4096];
   int car_const = -1, mod_const = -1;   // -1 selects the sine table
   // reference register file: shadow (s_) and active (m_)
   longint s_car_ftw, s_mod_ftw, s_amp, s_depth, s_mode, s_shift;
   longint m_car_ftw, m_mod_ftw, m_amp, m_depth, m_mode, m_shift;
   longint mc, mm;
   int e_dac[2048], e_acar[2048], e_amod[2048];
   bit e_wrap[2048];

   dds_mod_core #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .rom_addr_car(rom_addr_car), .rom_data_car(rom_data_car),
      .rom_addr_mod(rom_addr_mod), .rom_data_mod(rom_data_mod),
      .dac_out(dac_out), .out_valid(out_valid), .car_wrap(car_wrap));

   always #5 clk = ~clk;

   // external ROMs, one cycle read latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
      rom_data_car <= (car_const >= 0) ? 12'(car_const) : 12'(sin_tab[rom_addr_car]);
      rom_data_mod <= (mod_const >= 0) ? 12'(mod_const) : 12'(sin_tab[rom_addr_mod]);
   end

   task automatic model_defaults();
      s_car_ftw = 0; s_mod_ftw = 0; s_amp = 'h8000; s_depth = 0; s_mode = 0; s_shift = 0;
      m_car_ftw = 0; m_mod_ftw = 0; m_amp = 'h8000; m_depth = 0; m_mode = 0; m_shift = 0;
   endtask

   // expected DAC word for one carrier/modulator sample pair under the active config
   function automatic int exp_dac(input int c_raw, input int m_raw);
      longint cs, ms, ca, env, y;
      cs = c_raw - 2048;
      ms = m_raw - 2048;
      ca = (cs * m_amp) >>> 15;
      case (m_mode)
         1: begin env = 2048 + ((ms * m_depth) >>> 12); y = (ca * env) >>> 11; end
         3: y = (ca * ms) >>> 11;
         default: y = ca;
      endcase
      if (y > 2047) y = 2047;
      if (y < -2048) y = -2048;
      return int'(y + 2048);
   endfunction

   // advance the reference by one cycle; j=0 is the cycle the phase reset lands
   task automatic step_model(input int j);
      longint inc, sum;
      int cs, ms;
      if (j == 0) begin
         mc = 0; mm = 0; e_wrap[0] = 1'b0;
      end else begin
         inc = m_car_ftw;
         if (m_mode == 2) inc = inc + (longint'(mod_const - 2048) <<< m_shift);
         inc = inc & MASK32;
         sum = mc + inc;
         e_wrap[j] = (sum > MASK32);
         mc = sum & MASK32;
         mm = (mm + m_mod_ftw) & MASK32;
      end
      e_acar[j] = int'(mc >> 20);
      e_amod[j] = int'(mm >> 20);
      cs = (car_const >= 0) ? car_const : sin_tab[e_acar[j]];
      ms = (mod_const >= 0) ? mod_const : sin_tab[e_amod[j]];
      e_dac[j] = exp_dac(cs, ms);
   endtask

   // one config write; returns at the falling edge of the cycle after acceptance
   task automatic cfg_write(input int addr, input longint data);
      int waited = 0;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_addr = 3'(addr); cfg_data = 32'(data);
      while (!cfg_ready && waited < 16) begin @(negedge clk); waited++; end
      total++;
      if (cfg_ready !== 1'b1) begin
         bad++; $display("FAIL cfg_handshake addr=%0d ready=%b required=1", addr, cfg_ready);
      end
      case (addr)
         0: s_car_ftw = data;
         1: s_mod_ftw = data;
         2: s_amp = (data > 'h8000) ? 'h8000 : data;
         3: s_depth = data & 'hFFF;
         4: s_mode = data & 3;
         5: s_shift = data & 31;
         7: begin m_car_ftw = s_car_ftw; m_mod_ftw = s_mod_ftw; m_amp = s_amp;
                  m_depth = s_depth; m_mode = s_mode; m_shift = s_shift; end
         default: ;
      endcase
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (dac_out !== 12'h800 || car_wrap !== 1'b0 || out_valid !== 1'b0 || rom_addr_car !== 12'h0) begin
         bad++; $display("FAIL reset_state dac=%h wrap=%b valid=%b addr=%h required 800/0/0/000", dac_out, car_wrap, out_valid, rom_addr_car);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); @(negedge clk);
         total++;
         if (out_valid !== (k >= 5) || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release k=%0d valid=%b ready=%b required valid=%0d ready=1", k, out_valid, cfg_ready, k >= 5);
         end
      end
   endtask

   task automatic test_cw();
      int wraps = 0;
      car_const = -1; mod_const = -1;
      cfg_write(0, 'h0100_0000); cfg_write(7, 0); cfg_write(6, 0);
      for (int j = 0; j < 600; j++) begin
         @(posedge clk); step_model(j); @(negedge clk);
         if (j >= 1) begin
            total++;
            if (rom_addr_car !== 12'(e_acar[j-1])) begin bad++; $display("FAIL cw_addr j=%0d got=%h want=%h", j, rom_addr_car, 12'(e_acar[j-1])); end
         end
         if (j >= 4) begin
            total++;
            if (dac_out !== 12'(e_dac[j-4]) || car_wrap !== e_wrap[j-4]) begin
               bad++; $display("FAIL cw_dac j=%0d got=%h/%b want=%h/%b", j, dac_out, car_wrap, 12'(e_dac[j-4]), e_wrap[j-4]);
            end
            if (car_wrap === 1'b1) wraps++;
         end
      end
      total++;
      if (wraps != 2) begin bad++; $display("FAIL cw_wrap_count got=%0d want=2", wraps); end
   endtask

   task automatic test_shadow_commit();
      cfg_write(0, 'h0200_0000); cfg_write(1, 'h0001_0000); cfg_write(4, 3); cfg_write(6, 0);
      for (int j = 0; j < 100; j++) begin
         @(posedge clk); step_model(j); @(negedge clk);
         if (j >= 1) begin
            total++;
            if (rom_addr_car !== 12'(e_acar[j-1]) || rom_addr_mod !== 12'(e_amod[j-1])) begin
               bad++; $display("FAIL shadow_addr j=%0d got=%h/%h want=%h/%h", j, rom_addr_car, rom_addr_mod, 12'(e_acar[j-1]), 12'(e_amod[j-1]));
            end
         end
         if (j >= 4) begin
            total++;
            if (dac_out !== 12'(e_dac[j-4])) begin bad++; $display("FAIL shadow_dac j=%0d got=%h want=%h", j, dac_out, 12'(e_dac[j-4])); end
         end
      end
      cfg_write(7, 0);
      total++;
      if (cfg_ready !== 1'b0) begin bad++; $display("FAIL commit_ready_low got=%b want=0", cfg_ready); end
      @(negedge clk);
      total++;
      if (cfg_ready !== 1'b1) begin bad++; $display("FAIL commit_ready_high got=%b want=1", cfg_ready); end
      cfg_write(6, 0);
      for (int j = 0; j < 300; j++) begin
         @(posedge clk); step_model(j); @(negedge clk);
         if (j >= 1) begin
            total++;
            if (rom_addr_car !== 12'(e_acar[j-1]) || rom_addr_mod !== 12'(e_amod[j-1])) begin
               bad++; $display("FAIL commit_addr j=%0d got=%h/%h want=%h/%h", j, rom_addr_car, rom_addr_mod, 12'(e_acar[j-1]), 12'(e_amod[j-1]));
            end
         end
         if (j >= 4) begin
            total++;
            if (dac_out !== 12'(e_dac[j-4])) begin bad++; $display("FAIL commit_dac j=%0d got=%h want=%h", j, dac_out, 12'(e_dac[j-4])); end
         end
      end
   endtask

   task automatic test_am();
      car_const = 'hFFF; mod_const = 'hFFF;
      cfg_write(3, 'hFFF); cfg_write(2, 'h8000); cfg_write(4, 1); cfg_write(7, 0); cfg_write(6, 0);
      for (int j = 0; j < 20; j++) begin
         @(posedge clk); step_model(j); @(negedge clk);
         if (j >= 4) begin
            total++;
            if (dac_out !== 12'(e_dac[j-4])) begin bad++; $display("FAIL am_sat_model j=%0d got=%h want=%h", j, dac_out, 12'(e_dac[j-4])); end
         end
      end
      total++;
      if (dac_out !== 12'hFFF) begin bad++; $display("FAIL am_saturate got=%h want=fff", dac_out); end
      // zero depth with an over-unity amplitude write (clamped) must equal plain CW
      car_const = -1; mod_const = -1;
      cfg_write(3, 0); cfg_write(2, 'h9000); cfg_write(7, 0); cfg_write(6, 0);
      for (int j = 0; j < 300; j++) begin
         @(posedge clk); step_model(j); @(negedge clk);
         if (j >= 4) begin
            total++;
            if (dac_out !== 12'(sin_tab[e_acar[j-4]])) begin
               bad++; $display("FAIL am_depth0 j=%0d got=%h want=%h", j, dac_out, 12'(sin_tab[e_acar[j-4]]));
            end
         end
      end
   endtask

   task automatic test_fm();
      car_const = -1; mod_const = 'hA00;
      cfg_write(0, 'h0010_0000); cfg_write(5, 4); cfg_write(4, 2); cfg_write(2, 'h8000);
      cfg_write(7, 0); cfg_write(6, 0);
      for (int j = 0; j < 300; j++) begin
         @(posedge clk); step_model(j); @(negedge clk);
         if (j == 1 || j == 129) begin
            total++;
            if (rom_addr_car !== ((j == 1) ? 12'h000 : 12'h081)) begin
               bad++; $display("FAIL fm_increment j=%0d got=%h want=%h", j, rom_addr_car, (j == 1) ? 12'h000 : 12'h081);
            end
         end
         if (j >= 1) begin
            total++;
            if (rom_addr_car !== 12'(e_acar[j-1])) begin bad++; $display("FAIL fm_addr j=%0d got=%h want=%h", j, rom_addr_car, 12'(e_acar[j-1])); end
         end
         if (j >= 4) begin
            total++;
            if (dac_out !== 12'(e_dac[j-4])) begin bad++; $display("FAIL fm_dac j=%0d got=%h want=%h", j, dac_out, 12'(e_dac[j-4])); end
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         int md;
         md = $urandom_range(0, 3);
         car_const = -1;
         mod_const = (md == 2) ? int'($urandom_range(0, 4095)) : -1;
         cfg_write(0, longint'($urandom)); cfg_write(1, longint'($urandom));
         cfg_write(2, longint'($urandom_range(0, 'hFFFF))); cfg_write(3, longint'($urandom_range(0, 'hFFF)));
         cfg_write(4, md); cfg_write(5, longint'($urandom_range(0, 31)));
         cfg_write(7, 0); cfg_write(6, 0);
         for (int j = 0; j < 150; j++) begin
            @(posedge clk); step_model(j); @(negedge clk);
            if (j >= 4) begin
               total++;
               if (dac_out !== 12'(e_dac[j-4]) || car_wrap !== e_wrap[j-4]) begin
                  bad++; $display("FAIL rand_dac it=%0d mode=%0d j=%0d got=%h/%b want=%h/%b", it, md, j, dac_out, car_wrap, 12'(e_dac[j-4]), e_wrap[j-4]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int guard = 0;
      car_const = -1; mod_const = -1;
      cfg_write(0, 'h0123_4567); cfg_write(1, 'h0040_0000); cfg_write(3, 'h800); cfg_write(4, 1);
      cfg_write(7, 0); cfg_write(6, 0);
      for (int j = 0; cyc < 1000 && guard < 1200; j++) begin
         guard++;
         @(posedge clk); step_model(j); @(negedge clk);
         if (j >= 4) begin
            total++;
            if (dac_out !== 12'(e_dac[j-4])) begin bad++; $display("FAIL midrun_am j=%0d got=%h want=%h", j, dac_out, 12'(e_dac[j-4])); end
         end
      end
      cfg_write(4, 3);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_addr = 3'd7; cfg_data = '0;
      @(posedge clk);
      #1 rst_n = 1'b0; cfg_valid = 1'b0;
      #1;
      total++;
      if (dac_out !== 12'h800 || car_wrap !== 1'b0 || out_valid !== 1'b0 || rom_addr_car !== 12'h0 ||
          rom_addr_mod !== 12'h0 || cfg_ready !== 1'b1) begin
         bad++; $display("FAIL midrun_async dac=%h wrap=%b valid=%b addr=%h/%h ready=%b required 800/0/0/000/000/1",
                         dac_out, car_wrap, out_valid, rom_addr_car, rom_addr_mod, cfg_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      model_defaults();
      cfg_write(0, 'h0100_0000); cfg_write(7, 0); cfg_write(6, 0);
      for (int j = 0; j < 300; j++) begin
         @(posedge clk); step_model(j); @(negedge clk);
         if (j >= 1) begin
            total++;
            if (rom_addr_mod !== 12'(e_amod[j-1])) begin bad++; $display("FAIL midrun_modaddr j=%0d got=%h want=%h", j, rom_addr_mod, 12'(e_amod[j-1])); end
         end
         if (j >= 4) begin
            total++;
            if (dac_out !== 12'(e_dac[j-4])) begin bad++; $display("FAIL midrun_defaults j=%0d got=%h want=%h", j, dac_out, 12'(e_dac[j-4])); end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++)
         sin_tab[i] = 2048 + $rtoi($floor(2047.0 * $sin(2.0 * 3.14159265358979 * i / 4096.0) + 0.5));
      model_defaults();
      test_reset();
      test_cw();
      test_shadow_commit();
      test_am();
      test_fm();
      test_random();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dds_mod_core.md
Name: dds_mod_core

Overview:
- Parametrised two-channel DDS modulation engine: carrier and modulator phase accumulators, external sine-ROM lookup, carrier amplitude scaling, and run-time selectable CW/AM/FM/DSB output.
- Generalises the fixed carrier/modulator/AM datapath: width-parametrised, registered config interface with shadow/commit, phase-continuous FM and saturating output.
- Sits between the PLL-clocked system domain and the 12-bit DAC; sine ROM instances stay outside the block.

Parameters:
- PHASE_W, 32, phase accumulator and FTW width
- ADDR_W, 12, ROM address width (top ADDR_W bits of phase)
- DATA_W, 12, ROM sample and DAC width, offset-binary

Ports:
- clk  in  1  DDS sample clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_addr  in  3  register select
- cfg_data  in  PHASE_W  write data (LSB-aligned)
- rom_addr_car  out  ADDR_W  carrier ROM address, registered
- rom_data_car  in  DATA_W  carrier ROM data, 1-cycle latency
- rom_addr_mod  out  ADDR_W  modulator ROM address, registered
- rom_data_mod  in  DATA_W  modulator ROM data, 1-cycle latency
- dac_out  out  DATA_W  offset-binary DAC sample
- out_valid  out  1  pipeline primed
- car_wrap  out  1  one-cycle pulse on carrier phase overflow, pipeline-aligned with dac_out

Behaviour:
- Registers (shadow): 0 car_ftw, 1 mod_ftw, 2 car_amp[15:0] (0x8000 = unity; writes > 0x8000 clamp to 0x8000), 3 am_depth[DATA_W-1:0], 4 mode[1:0] (0 CW, 1 AM, 2 FM, 3 DSB), 5 fm_shift[4:0], 6 phase reset strobe, 7 commit strobe.
- Addr 0-5 write shadows only. Commit copies all shadows to active registers in the cycle after acceptance; cfg_ready is low in exactly that cycle, high otherwise after reset.
- Phase reset zeroes both accumulators in the cycle after acceptance. Phase reset takes priority over accumulation in that cycle. It does not commit shadows.
- Reset values:
  - Shadow and active: car_ftw=0, mod_ftw=0, car_amp=0x8000, am_depth=0, mode=0, fm_shift=0.
  - Accumulators 0, dac_out = 2^(DATA_W-1), out_valid=0, car_wrap=0, rom addresses 0.
- Accumulators wrap modulo 2^PHASE_W.
  - Modulator: mod_ph += mod_ftw.
  - Carrier: car_ph += car_ftw, or in FM car_ph += car_ftw + sext(m_s <<< fm_shift).
- Pipeline:
  - S0: accumulators.
  - S1: rom_addr = ph[PHASE_W-1 -: ADDR_W].
  - S2: ROM data returns.
  - S3: signed conversion s = data - 2^(DATA_W-1), then car_a = (car_s*car_amp) >>> 15.
  - S4: modulation and saturation.
  - S5: dac_out register.
- Latency from accumulator value to dac_out: 4 cycles. car_wrap is delayed identically.
- FM uses the m_s currently in S3.
- out_valid rises 5 cycles after rst_n release and stays high.
- Mode arithmetic:
  - CW: y = car_a.
  - AM: env = 2^(DATA_W-1) + ((m_s*am_depth) >>> DATA_W), y = (car_a*env) >>> (DATA_W-1).
  - DSB: y = (car_a*m_s) >>> (DATA_W-1).
  - FM: y = car_a.
- y saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. dac_out = y + 2^(DATA_W-1).
- A mode change at commit takes effect in S4 at the same cycle the active register updates; no flush.
- rst_n assertion mid-operation returns every output to its reset value asynchronously. A pending commit is lost.

Optional Feature:
- Macro: DDS_DITHER_EN.
- Defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset) advances every cycle. Its top (PHASE_W-ADDR_W) bits, capped at 16 and LSB-aligned, are added to each phase before truncation in S1. The accumulators themselves are undithered.
- Undefined: plain truncation; LFSR absent.

Test Plan (PHASE_W=32, ADDR_W=12, DATA_W=12, bench ROM model sin table, 1-cycle latency):
- Reset: hold rst_n=0 then release -> dac_out=0x800, car_wrap=0, cfg_ready=1; out_valid=0 until 5th clk after release, then 1.
- CW: write car_ftw=0x0100_0000, commit -> car_wrap pulses every 256 cycles; dac_out = ROM[car_ph[31:20]] exactly, 4 cycles after the accumulator.
- Shadow/commit: write car_ftw=0x0200_0000 and mod_ftw=0x0001_0000 without commit -> frequency unchanged. Commit -> cfg_ready low one cycle, then both new increments apply in the same cycle.
- AM: bench mod ROM returns constant 0xFFF, am_depth=0xFFF, car_amp=0x8000, car sample 0xFFF -> y saturates, dac_out=0xFFF. With am_depth=0 -> output identical to CW.
- FM: mod ROM constant 0xA00 (m_s=512), fm_shift=4, car_ftw=0x0010_0000 -> carrier increment 0x0010_2000 per cycle. Phase reset strobe -> car_ph=0 next cycle.
- Reset mid-run: assert rst_n during AM at cycle 1000 with a commit in flight -> outputs reset immediately, active registers return to defaults.
